// File: rtl/idli_pkg.sv
// ============================================================================
// Package : idli_pkg
// Purpose : Shared types for the idli core datapath: register index, the
//           4-bit serial data slice and the ALU operation encoding.
// Revision: 1.0 - initial ALU types
// ============================================================================
`default_nettype none

package idli_pkg;

  // General-purpose register index (r0..r7).
  typedef logic [2:0] greg_t;

  // One nibble of a 16-bit register as it rotates past the datapath.
  typedef logic [3:0] sqi_data_t;

  // ALU operation encoding.
  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_ANDN   = 3'd5,
    ALU_CMP_EQ = 3'd6,
    ALU_CMP_LT = 3'd7
  } alu_op_t;

  // Ops that run through the adder with an inverted RHS and carry-in of 1.
  function automatic logic alu_op_is_sub(input alu_op_t op);
    return (op == ALU_SUB) || (op == ALU_CMP_EQ) || (op == ALU_CMP_LT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/idli_alu_slice_m.sv
// ============================================================================
// Module  : idli_alu_slice_m
// Purpose : Purely combinational 4-bit ALU slice. Computes one result nibble
//           plus the carry-out, nibble-equal and signed less-than terms.
// Ports   : i_op       operation for this nibble
//           i_first    high on nibble 0 (selects the initial carry-in)
//           i_carry    carry from the previous nibble
//           i_lhs/rhs  input slices
//           o_res      result nibble
//           o_carry    adder carry-out
//           o_eq       lhs == rhs for this nibble
//           o_lt       signed lhs < rhs, meaningful on the top nibble only
// Revision: 1.0 - initial
// ============================================================================
`default_nettype none

module idli_alu_slice_m
  import idli_pkg::*;
(
  input  alu_op_t   i_op,
  input  logic      i_first,
  input  logic      i_carry,
  input  sqi_data_t i_lhs,
  input  sqi_data_t i_rhs,
  output sqi_data_t o_res,
  output logic      o_carry,
  output logic      o_eq,
  output logic      o_lt
);

  logic      is_sub;
  logic      cin;
  sqi_data_t rhs_eff;
  logic [4:0] sum;
  logic      ov;

  always_comb begin
    is_sub  = alu_op_is_sub(i_op);
    rhs_eff = is_sub ? ~i_rhs : i_rhs;
    // Subtraction is lhs + ~rhs + 1; the +1 enters only on nibble 0.
    cin     = i_first ? is_sub : i_carry;
    sum     = {1'b0, i_lhs} + {1'b0, rhs_eff} + {4'b0000, cin};

    // Two's-complement overflow of the top nibble corrects the sign bit.
    ov      = (i_lhs[3] == rhs_eff[3]) && (sum[3] != i_lhs[3]);
    o_lt    = sum[3] ^ ov;
    o_eq    = (i_lhs == i_rhs);
    o_carry = sum[4];

    o_res = sum[3:0];
    case (i_op)
      ALU_AND:  o_res = i_lhs & i_rhs;
      ALU_OR:   o_res = i_lhs | i_rhs;
      ALU_XOR:  o_res = i_lhs ^ i_rhs;
      ALU_ANDN: o_res = i_lhs & ~i_rhs;
      default:  o_res = sum[3:0];
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/idli_alu_m.sv
// ============================================================================
// Module  : idli_alu_m
// Purpose : Nibble-serial 16-bit ALU. One op takes four cycles, LS nibble
//           first; each result nibble goes straight back to the register file
//           write port on the same cycle.
// Ports   : i_alu_gck / i_alu_rst_n   clock, async active-low reset
//           i_alu_start/op/dst        operation request (nibble 0 when idle)
//           i_alu_lhs/rhs_data        operand slices from the register file
//           o_alu_busy                nibbles 1..3 in progress
//           o_alu_wr/_en/_data        register file write port
//           o_alu_flag                last compare result
//           o_alu_done                pulse on the cycle after nibble 3
// Revision: 1.0 - initial
// ============================================================================
`default_nettype none

module idli_alu_m
  import idli_pkg::*;
(
  input  logic      i_alu_gck,
  input  logic      i_alu_rst_n,
  input  logic      i_alu_start,
  input  alu_op_t   i_alu_op,
  input  greg_t     i_alu_dst,
  input  sqi_data_t i_alu_lhs_data,
  input  sqi_data_t i_alu_rhs_data,
  output logic      o_alu_busy,
  output greg_t     o_alu_wr,
  output logic      o_alu_wr_en,
  output sqi_data_t o_alu_wr_data,
  output logic      o_alu_flag,
  output logic      o_alu_done
);

  logic       active_q, active_d;
  logic [1:0] cnt_q,    cnt_d;
  logic       carry_q,  carry_d;
  logic       eq_q,     eq_d;
  alu_op_t    op_q,     op_d;
  greg_t      dst_q,    dst_d;
  logic       flag_q,   flag_d;
  logic       done_q,   done_d;

  logic       idle_start;
  logic       pipe_start;
  logic       cur_active;
  logic [1:0] nib;
  alu_op_t    cur_op;
  greg_t      cur_dst;
  logic       first;
  logic       is_cmp;

  sqi_data_t  slice_res;
  logic       slice_carry;
  logic       slice_eq;
  logic       slice_lt;

  always_comb begin
    // Gating with reset keeps the write port quiet while reset is held even
    // if start is asserted.
    idle_start = i_alu_start && !active_q && i_alu_rst_n;
    // A start during nibble 3 queues the next op; its nibble 0 is next cycle.
    pipe_start = i_alu_start && active_q && (cnt_q == 2'd3);
    cur_active = active_q || idle_start;
    nib        = idle_start ? 2'd0 : cnt_q;
    cur_op     = idle_start ? i_alu_op  : op_q;
    cur_dst    = idle_start ? i_alu_dst : dst_q;
    first      = cur_active && (nib == 2'd0);
    is_cmp     = (cur_op == ALU_CMP_EQ) || (cur_op == ALU_CMP_LT);
  end

  idli_alu_slice_m u_slice (
    .i_op    (cur_op),
    .i_first (first),
    .i_carry (carry_q),
    .i_lhs   (i_alu_lhs_data),
    .i_rhs   (i_alu_rhs_data),
    .o_res   (slice_res),
    .o_carry (slice_carry),
    .o_eq    (slice_eq),
    .o_lt    (slice_lt)
  );

  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    eq_d     = eq_q;
    op_d     = op_q;
    dst_d    = dst_q;
    flag_d   = flag_q;
    done_d   = 1'b0;

    if (idle_start) begin
      op_d  = i_alu_op;
      dst_d = i_alu_dst;
    end

    if (cur_active) begin
      carry_d = slice_carry;
      eq_d    = first ? slice_eq : (eq_q && slice_eq);

      if (nib == 2'd3) begin
        done_d = 1'b1;
        if (cur_op == ALU_CMP_EQ) flag_d = eq_q && slice_eq;
        if (cur_op == ALU_CMP_LT) flag_d = slice_lt;

        cnt_d = 2'd0;
        if (pipe_start) begin
          active_d = 1'b1;
          op_d     = i_alu_op;
          dst_d    = i_alu_dst;
        end else begin
          active_d = 1'b0;
        end
      end else begin
        active_d = 1'b1;
        cnt_d    = nib + 2'd1;
      end
    end
  end

  always_ff @(posedge i_alu_gck or negedge i_alu_rst_n) begin
    if (!i_alu_rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      eq_q     <= 1'b0;
      op_q     <= ALU_ADD;
      dst_q    <= '0;
      flag_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      eq_q     <= eq_d;
      op_q     <= op_d;
      dst_q    <= dst_d;
      flag_q   <= flag_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    // A queued op sits in its nibble-0 cycle with cnt_q == 0; not busy then.
    o_alu_busy    = active_q && (cnt_q != 2'd0);
    o_alu_wr_en   = cur_active && !is_cmp;
    o_alu_wr      = cur_active ? cur_dst   : '0;
    o_alu_wr_data = cur_active ? slice_res : '0;
    o_alu_flag    = flag_q;
    o_alu_done    = done_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_idli_alu_m.sv
// ============================================================================
// Module  : tb_idli_alu_m
// Purpose : Self-checking bench for idli_alu_m. Inputs change on the falling
//           edge and outputs are sampled 2ns later, before the rising edge.
// Revision: 1.0 - initial
// ============================================================================
`default_nettype none

module tb_idli_alu_m;
  import idli_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      start;
  alu_op_t   op;
  greg_t     dst;
  sqi_data_t lhs;
  sqi_data_t rhs;
  logic      busy;
  greg_t     wr;
  logic      wr_en;
  sqi_data_t wr_data;
  logic      flag;
  logic      done;

  int checks = 0;
  int errors = 0;
  logic mflag = 1'b0;

  idli_alu_m dut (
    .i_alu_gck      (clk),
    .i_alu_rst_n    (rst_n),
    .i_alu_start    (start),
    .i_alu_op       (op),
    .i_alu_dst      (dst),
    .i_alu_lhs_data (lhs),
    .i_alu_rhs_data (rhs),
    .o_alu_busy     (busy),
    .o_alu_wr       (wr),
    .o_alu_wr_en    (wr_en),
    .o_alu_wr_data  (wr_data),
    .o_alu_flag     (flag),
    .o_alu_done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    alu_op_t     op;
    greg_t       dst;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        flag;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word arithmetic; compares report lhs - rhs on wr_data.
  function automatic logic [15:0] model_res(input alu_op_t o, input logic [15:0] a, input logic [15:0] b);
    case (o)
      ALU_ADD:  return a + b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_ANDN: return a & ~b;
      default:  return a - b;
    endcase
  endfunction

  function automatic logic model_flag(input alu_op_t o, input logic [15:0] a, input logic [15:0] b, input logic prev);
    if (o == ALU_CMP_EQ) return a == b;
    if (o == ALU_CMP_LT) return $signed(a) < $signed(b);
    return prev;
  endfunction

  function automatic logic is_wr(input alu_op_t o);
    return (o != ALU_CMP_EQ) && (o != ALU_CMP_LT);
  endfunction

  task automatic idle_inputs();
    start = 1'b0;
    op    = alu_op_t'(3'($urandom));
    dst   = greg_t'($urandom);
    lhs   = sqi_data_t'($urandom);
    rhs   = sqi_data_t'($urandom);
  endtask

  // One isolated operation: nibbles on cycles 0..3, done/flag on cycle 4.
  task automatic run_op(input alu_op_t o, input greg_t d, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res, input logic exp_flag);
    logic [15:0] got;
    got = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == 0) begin
        start = 1'b1;
        op    = o;
        dst   = d;
      end
      lhs = a[4*k +: 4];
      rhs = b[4*k +: 4];
      #2;
      got[4*k +: 4] = wr_data;
      chk("wr_en", {15'd0, wr_en}, {15'd0, is_wr(o)});
      chk("wr_idx", {13'd0, wr}, {13'd0, d});
      chk("busy", {15'd0, busy}, {15'd0, (k != 0)});
      chk("done_early", {15'd0, done}, 16'd0);
    end
    chk("result", got, exp_res);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("done", {15'd0, done}, 16'd1);
    chk("flag", {15'd0, flag}, {15'd0, exp_flag});
    chk("wr_en_after", {15'd0, wr_en}, 16'd0);
    mflag = exp_flag;
  endtask

  // Second op is requested on nibble 3 of the first; its nibble 0 follows.
  task automatic run_b2b(input alu_op_t o1, input greg_t d1, input logic [15:0] a1, input logic [15:0] b1,
                         input logic [15:0] e1, input alu_op_t o2, input greg_t d2,
                         input logic [15:0] a2, input logic [15:0] b2, input logic [15:0] e2);
    logic [15:0] g1, g2;
    g1 = '0;
    g2 = '0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin start = 1'b1; op = o1; dst = d1; end
      if (c == 3) begin start = 1'b1; op = o2; dst = d2; end
      if (c < 4) begin
        lhs = a1[4*c +: 4];
        rhs = b1[4*c +: 4];
      end else if (c < 8) begin
        lhs = a2[4*(c-4) +: 4];
        rhs = b2[4*(c-4) +: 4];
      end
      #2;
      if (c < 4) g1[4*c +: 4] = wr_data;
      else if (c < 8) g2[4*(c-4) +: 4] = wr_data;
      chk("b2b_done", {15'd0, done}, {15'd0, (c == 4 || c == 8)});
      if (c < 8) begin
        chk("b2b_wr_en", {15'd0, wr_en}, {15'd0, (c < 4) ? is_wr(o1) : is_wr(o2)});
        chk("b2b_wr_idx", {13'd0, wr}, {13'd0, (c < 4) ? d1 : d2});
      end
    end
    chk("b2b_res1", g1, e1);
    chk("b2b_res2", g2, e2);
    mflag = model_flag(o2, a2, b2, model_flag(o1, a1, b1, mflag));
    chk("b2b_flag", {15'd0, flag}, {15'd0, mflag});
  endtask

  vec_t vecs[8];

  initial begin
    logic [15:0] a, b;
    alu_op_t     o;
    logic        ef;

    vecs[0] = '{ALU_ADD,    3'd3, 16'h1234, 16'h0FFF, 16'h2233, 1'b0};
    vecs[1] = '{ALU_SUB,    3'd1, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[2] = '{ALU_CMP_LT, 3'd2, 16'h8000, 16'h0001, 16'h7FFF, 1'b1};
    vecs[3] = '{ALU_CMP_LT, 3'd2, 16'h7FFF, 16'h8000, 16'hFFFF, 1'b0};
    vecs[4] = '{ALU_CMP_EQ, 3'd4, 16'hABCD, 16'hABCD, 16'h0000, 1'b1};
    vecs[5] = '{ALU_OR,     3'd5, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b1};
    vecs[6] = '{ALU_XOR,    3'd6, 16'hFFFF, 16'h1234, 16'hEDCB, 1'b1};
    vecs[7] = '{ALU_AND,    3'd7, 16'hF0F0, 16'hFF00, 16'hF000, 1'b1};

    rst_n = 1'b0;
    start = 1'b0;
    op    = ALU_ADD;
    dst   = '0;
    lhs   = '0;
    rhs   = '0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_wr", {13'd0, wr}, 16'd0);
    chk("rst_wr_en", {15'd0, wr_en}, 16'd0);
    chk("rst_wr_data", {12'd0, wr_data}, 16'd0);
    chk("rst_flag", {15'd0, flag}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i])
      run_op(vecs[i].op, vecs[i].dst, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].flag);

    // Back-to-back, including a carry-out of the first op that must not leak.
    run_b2b(ALU_ADD, 3'd2, 16'h000F, 16'h0001, 16'h0010, ALU_ANDN, 3'd6, 16'hFFFF, 16'h00F0, 16'hFF0F);
    run_b2b(ALU_ADD, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, ALU_ADD,  3'd7, 16'h0001, 16'h0001, 16'h0002);
    run_b2b(ALU_SUB, 3'd4, 16'h0005, 16'h0003, 16'h0002, ALU_CMP_LT, 3'd0, 16'hFFFE, 16'h0001, 16'hFFFD);

    // Start while busy is ignored.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin start = 1'b1; op = ALU_ADD; dst = 3'd3; end
      if (c == 1) begin start = 1'b1; op = ALU_SUB; dst = 3'd5; end
      if (c < 4) begin
        a = 16'h1234;
        b = 16'h0FFF;
        lhs = a[4*c +: 4];
        rhs = b[4*c +: 4];
      end
      #2;
      if (c < 4) begin
        a = 16'h2233;
        chk("busy_start_data", {12'd0, wr_data}, {12'd0, a[4*c +: 4]});
        chk("busy_start_idx", {13'd0, wr}, 16'd3);
      end
      chk("busy_start_done", {15'd0, done}, {15'd0, (c == 4)});
      if (c == 5) chk("busy_start_idle", {15'd0, wr_en}, 16'd0);
    end

    // Reset during nibble 2 aborts the op and clears the flag.
    run_op(ALU_CMP_EQ, 3'd0, 16'h5A5A, 16'h5A5A, 16'h0000, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 0) begin start = 1'b1; op = ALU_ADD; dst = 3'd6; end
      lhs = 4'h1;
      rhs = 4'h2;
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_wr_en", {15'd0, wr_en}, 16'd0);
    chk("arst_wr_data", {12'd0, wr_data}, 16'd0);
    chk("arst_wr", {13'd0, wr}, 16'd0);
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_flag", {15'd0, flag}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mflag = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      start = 1'b0;
      #2;
      chk("arst_no_done", {15'd0, done}, 16'd0);
      chk("arst_flag_hold", {15'd0, flag}, 16'd0);
    end

    // Randomized operations against the word-level model.
    for (int n = 0; n < 40; n++) begin
      o = alu_op_t'(3'($urandom_range(0, 7)));
      case ($urandom_range(0, 3))
        0:       a = 16'h8000;
        1:       a = 16'hFFFF;
        default: a = 16'($urandom);
      endcase
      b  = ($urandom_range(0, 4) == 0) ? a : 16'($urandom);
      ef = model_flag(o, a, b, mflag);
      run_op(o, greg_t'($urandom), a, b, model_res(o, a, b), ef);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
